uart_rx_fifo: RTL and testbench

- Next-generation UART receiver with parametrised data width and parity mode.
- Baud rate is programmed at runtime through an oversample divisor, not fixed by a parameter.
- Uses 3-sample majority voting per bit and buffers received words in an internal synchronous FIFO with a valid/ready read interface.
- Sits between the board RXD pin and the consumer logic; frame, parity and overrun errors are reported as pulses.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_sync_fifo.sv | 58 +++++
 rtl/uart_rx_fifo.sv | 262 ++++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: parity mode names, oversampling
// timing, receiver FSM encoding and a 3-input majority helper.
package uart_pkg;

    localparam string PAR_NONE  = "none";
    localparam string PAR_EVEN  = "even";
    localparam string PAR_ODD   = "odd";
    localparam string PAR_MARK  = "mark";
    localparam string PAR_SPACE = "space";

    localparam int OS_RATE    = 16;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;

    typedef enum logic [2:0] {
        PM_NONE,
        PM_EVEN,
        PM_ODD,
        PM_MARK,
        PM_SPACE
    } parity_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO: push/full/count on the write side, valid/ready on
// the read side. A push into a full FIFO is accepted only when a pop happens too.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push;
    logic             pop;

    assign rd_valid = (count_reg != '0);
    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign count    = count_reg;
    assign pop      = rd_valid && rd_ready;
    assign push     = wr_en && (!full || pop);

    // Head word is masked while empty so the output reads zero, not stale data.
    assign rd_data  = rd_valid ? mem[rd_ptr_reg] : '0;

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority voting feeding an RX FIFO.
// Define UART_RX_BREAK_DET_EN to enable break detection and the BREAK output.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int    DATA_BITS  = 8,
    parameter string PARITY_BIT = "none",
    parameter int    FIFO_DEPTH = 16,
    parameter int    DIV_WIDTH  = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [DIV_WIDTH-1:0]          BAUD_DIV,
    input  logic                          UART_RXD,
    output logic [DATA_BITS-1:0]          DOUT,
    output logic                          DOUT_VLD,
    input  logic                          DOUT_RDY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          FRAME_ERROR,
    output logic                          PARITY_ERROR,
    output logic                          OVERRUN,
    output logic                          BREAK
);

    localparam parity_mode_t PAR_MODE =
        (PARITY_BIT == PAR_EVEN)  ? PM_EVEN  :
        (PARITY_BIT == PAR_ODD)   ? PM_ODD   :
        (PARITY_BIT == PAR_MARK)  ? PM_MARK  :
        (PARITY_BIT == PAR_SPACE) ? PM_SPACE : PM_NONE;
    localparam int OSW = $clog2(OS_RATE);
    localparam int BCW = $clog2(DATA_BITS);

    logic                 rxd_meta_reg;
    logic                 rxd_sync_reg;
    logic [DIV_WIDTH-1:0] div_cnt_reg;
    logic [DIV_WIDTH-1:0] baud_shadow_reg;
    logic                 tick;

    rx_state_t            state_reg, state_next;
    logic [OSW-1:0]       os_cnt_reg, os_cnt_next;
    logic [BCW-1:0]       bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 s_lo_reg, s_lo_next;
    logic                 s_mid_reg, s_mid_next;
    logic                 par_flag_reg, par_flag_next;
    logic                 push_reg, push_next;
    logic                 frame_err_reg, frame_err_next;
    logic                 parity_err_reg, parity_err_next;
    logic                 overrun_reg;
    logic                 fifo_full;
    logic [OSW-1:0]       tick_idx;
    logic                 maj;
    logic                 exp_par;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rxd_meta_reg <= 1'b1;
            rxd_sync_reg <= 1'b1;
        end else begin
            rxd_meta_reg <= UART_RXD;
            rxd_sync_reg <= rxd_meta_reg;
        end
    end

    // Divisor only follows BAUD_DIV between frames so a frame keeps one bit period.
    assign tick = (div_cnt_reg >= baud_shadow_reg);

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt_reg     <= '0;
            baud_shadow_reg <= DIV_WIDTH'(1);
        end else begin
            div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
            if (state_reg == ST_IDLE) begin
                baud_shadow_reg <= (BAUD_DIV == '0) ? DIV_WIDTH'(1) : BAUD_DIV;
            end
        end
    end

    assign tick_idx = os_cnt_reg + 1'b1;
    assign maj      = majority3(s_lo_reg, s_mid_reg, rxd_sync_reg);

    always_comb begin
        exp_par = 1'b0;
        case (PAR_MODE)
            PM_EVEN: exp_par = ^shift_reg;
            PM_ODD:  exp_par = ~^shift_reg;
            PM_MARK: exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
    end

`ifdef UART_RX_BREAK_DET_EN
    logic par_bit_reg, par_bit_next;
    logic break_reg, break_next;
`endif

    always_comb begin
        state_next      = state_reg;
        os_cnt_next     = os_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        s_lo_next       = s_lo_reg;
        s_mid_next      = s_mid_reg;
        par_flag_next   = par_flag_reg;
        push_next       = 1'b0;
        frame_err_next  = 1'b0;
        parity_err_next = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        par_bit_next    = par_bit_reg;
        break_next      = break_reg;
`endif

        // Bit-timing bookkeeping shared by every in-frame state.
        if (tick && state_reg != ST_IDLE && state_reg != ST_BRK_WAIT) begin
            os_cnt_next = tick_idx;
            if (tick_idx == OSW'(SAMPLE_LO)) begin
                s_lo_next = rxd_sync_reg;
            end
            if (tick_idx == OSW'(SAMPLE_MID)) begin
                s_mid_next = rxd_sync_reg;
            end
        end

        case (state_reg)
            ST_IDLE: begin
                if (tick && !rxd_sync_reg) begin
                    state_next    = ST_START;
                    os_cnt_next   = '0;
                    bit_cnt_next  = '0;
                    par_flag_next = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                    par_bit_next  = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (tick && tick_idx == OSW'(SAMPLE_HI) && maj) begin
                    state_next = ST_IDLE;
                end else if (tick && tick_idx == OSW'(OS_RATE-1)) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick && tick_idx == OSW'(SAMPLE_HI)) begin
                    shift_next = {maj, shift_reg[DATA_BITS-1:1]};
                end
                if (tick && tick_idx == OSW'(OS_RATE-1)) begin
                    if (bit_cnt_reg == BCW'(DATA_BITS-1)) begin
                        state_next = (PAR_MODE != PM_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick && tick_idx == OSW'(SAMPLE_HI)) begin
                    par_flag_next = (maj != exp_par);
`ifdef UART_RX_BREAK_DET_EN
                    par_bit_next  = maj;
`endif
                end
                if (tick && tick_idx == OSW'(OS_RATE-1)) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Decide mid stop bit and return to IDLE at once so a late stop edge resyncs.
                if (tick && tick_idx == OSW'(SAMPLE_HI)) begin
                    state_next = ST_IDLE;
`ifdef UART_RX_BREAK_DET_EN
                    if (!maj && shift_reg == '0 && !par_bit_reg) begin
                        state_next = ST_BRK_WAIT;
                        break_next = 1'b1;
                    end else
`endif
                    if (!maj) begin
                        frame_err_next = 1'b1;
                    end else if (par_flag_reg) begin
                        parity_err_next = 1'b1;
                    end else begin
                        push_next = 1'b1;
                    end
                end
            end
`ifdef UART_RX_BREAK_DET_EN
            ST_BRK_WAIT: begin
                if (tick && rxd_sync_reg) begin
                    state_next = ST_IDLE;
                    break_next = 1'b0;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= ST_IDLE;
            os_cnt_reg     <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            s_lo_reg       <= 1'b1;
            s_mid_reg      <= 1'b1;
            par_flag_reg   <= 1'b0;
            push_reg       <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            os_cnt_reg     <= os_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            s_lo_reg       <= s_lo_next;
            s_mid_reg      <= s_mid_next;
            par_flag_reg   <= par_flag_next;
            push_reg       <= push_next;
            frame_err_reg  <= frame_err_next;
            parity_err_reg <= parity_err_next;
            overrun_reg    <= push_reg && fifo_full && !(DOUT_VLD && DOUT_RDY);
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            par_bit_reg <= 1'b0;
            break_reg   <= 1'b0;
        end else begin
            par_bit_reg <= par_bit_next;
            break_reg   <= break_next;
        end
    end
    assign BREAK = break_reg;
`else
    assign BREAK = 1'b0;
`endif

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .srst     (RST),
        .wr_en    (push_reg),
        .wr_data  (shift_reg),
        .full     (fifo_full),
        .rd_data  (DOUT),
        .rd_valid (DOUT_VLD),
        .rd_ready (DOUT_RDY),
        .count    (FIFO_COUNT)
    );

    assign FRAME_ERROR  = frame_err_reg;
    assign PARITY_ERROR = parity_err_reg;
    assign OVERRUN      = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 depth-4 instance and an 8E1 depth-16
// instance, each driven on its own serial line at BAUD_DIV = 3 (64 clocks per bit).
module tb_uart_rx_fifo;

    localparam int BIT_CLKS = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'd3;
    logic        rxd_n = 1'b1;
    logic        rxd_e = 1'b1;
    logic        rdy_n = 1'b0;
    logic        rdy_e = 1'b0;

    logic [7:0]  dout_n, dout_e;
    logic        vld_n, vld_e;
    logic [2:0]  cnt_n;
    logic [4:0]  cnt_e;
    logic        fe_n, pe_n, ov_n, brk_n;
    logic        fe_e, pe_e, ov_e, brk_e;

    int checks = 0;
    int failures = 0;
    int fe_cnt_n = 0, pe_cnt_n = 0, ov_cnt_n = 0;
    int fe_cnt_e = 0, pe_cnt_e = 0, ov_cnt_e = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DATA_BITS(8), .PARITY_BIT("none"), .FIFO_DEPTH(4), .DIV_WIDTH(16)
    ) dut_n (
        .CLK(clk), .RST(rst), .BAUD_DIV(baud_div), .UART_RXD(rxd_n),
        .DOUT(dout_n), .DOUT_VLD(vld_n), .DOUT_RDY(rdy_n), .FIFO_COUNT(cnt_n),
        .FRAME_ERROR(fe_n), .PARITY_ERROR(pe_n), .OVERRUN(ov_n), .BREAK(brk_n)
    );

    uart_rx_fifo #(
        .DATA_BITS(8), .PARITY_BIT("even"), .FIFO_DEPTH(16), .DIV_WIDTH(16)
    ) dut_e (
        .CLK(clk), .RST(rst), .BAUD_DIV(baud_div), .UART_RXD(rxd_e),
        .DOUT(dout_e), .DOUT_VLD(vld_e), .DOUT_RDY(rdy_e), .FIFO_COUNT(cnt_e),
        .FRAME_ERROR(fe_e), .PARITY_ERROR(pe_e), .OVERRUN(ov_e), .BREAK(brk_e)
    );

    always @(posedge clk) begin
        if (fe_n) fe_cnt_n <= fe_cnt_n + 1;
        if (pe_n) pe_cnt_n <= pe_cnt_n + 1;
        if (ov_n) ov_cnt_n <= ov_cnt_n + 1;
        if (fe_e) fe_cnt_e <= fe_cnt_e + 1;
        if (pe_e) pe_cnt_e <= pe_cnt_e + 1;
        if (ov_e) ov_cnt_e <= ov_cnt_e + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_line(input bit to_e, input logic b);
        if (to_e) rxd_e = b;
        else      rxd_n = b;
    endtask

    // One frame, LSB first, followed by half a bit of idle.
    task automatic send(input bit to_e, input logic [7:0] data, input logic par, input logic stop);
        logic [10:0] frame;
        int nbits;
        frame = to_e ? {stop, par, data, 1'b0} : {1'b0, stop, data, 1'b0};
        nbits = to_e ? 11 : 10;
        $display("tx %s data=%02h par=%0b stop=%0b", to_e ? "8E1" : "8N1", data, par, stop);
        for (int i = 0; i < nbits; i++) begin
            set_line(to_e, frame[i]);
            repeat (BIT_CLKS) @(negedge clk);
        end
        set_line(to_e, 1'b1);
        repeat (BIT_CLKS / 2) @(negedge clk);
    endtask

    task automatic pop_chk(input bit to_e, input logic [7:0] exp, input string tag);
        chk({tag, "_vld"}, to_e ? 32'(vld_e) : 32'(vld_n), 1);
        chk(tag, to_e ? 32'(dout_e) : 32'(dout_n), 32'(exp));
        if (to_e) rdy_e = 1'b1; else rdy_n = 1'b1;
        @(negedge clk);
        rdy_e = 1'b0;
        rdy_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain_n();
        for (int i = 0; i < 8 && vld_n; i++) begin
            rdy_n = 1'b1;
            @(negedge clk);
            rdy_n = 1'b0;
            @(negedge clk);
        end
        chk("drain_empty", 32'(vld_n), 0);
    endtask

    int fe0, pe0, ov0;
    logic [9:0] frame77;

    initial begin
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        chk("rst_vld", 32'(vld_n), 0);
        chk("rst_cnt", 32'(cnt_n), 0);
        chk("rst_dout", 32'(dout_n), 0);
        chk("rst_brk", 32'(brk_n), 0);
        chk("rst_cnt_e", 32'(cnt_e), 0);

        // Clean 8N1 word
        fe0 = fe_cnt_n; pe0 = pe_cnt_n; ov0 = ov_cnt_n;
        send(0, 8'hA5, 1'b0, 1'b1);
        chk("a5_cnt", 32'(cnt_n), 1);
        chk("a5_errs", 32'(fe_cnt_n - fe0 + pe_cnt_n - pe0 + ov_cnt_n - ov0), 0);
        pop_chk(0, 8'hA5, "a5_dout");
        chk("a5_cnt_after_pop", 32'(cnt_n), 0);

        // Even parity: 0x03 needs parity 0, so 1 is an error
        fe0 = fe_cnt_e; pe0 = pe_cnt_e;
        send(1, 8'h03, 1'b1, 1'b1);
        chk("par_bad_pe", 32'(pe_cnt_e - pe0), 1);
        chk("par_bad_cnt", 32'(cnt_e), 0);
        send(1, 8'h03, 1'b0, 1'b1);
        chk("par_ok_cnt", 32'(cnt_e), 1);
        chk("par_ok_pe", 32'(pe_cnt_e - pe0), 1);
        chk("par_fe", 32'(fe_cnt_e - fe0), 0);
        pop_chk(1, 8'h03, "par_ok_dout");

        // Stop bit low
        fe0 = fe_cnt_n;
        send(0, 8'h55, 1'b0, 1'b0);
        repeat (2 * BIT_CLKS) @(negedge clk);
        chk("frm_fe", 32'(fe_cnt_n - fe0), 1);
        chk("frm_cnt", 32'(cnt_n), 0);
        send(0, 8'h3C, 1'b0, 1'b1);
        chk("frm_next_cnt", 32'(cnt_n), 1);
        pop_chk(0, 8'h3C, "frm_next_dout");

        // Overrun on depth-4 FIFO
        ov0 = ov_cnt_n;
        for (int d = 1; d <= 5; d++) send(0, 8'(d), 1'b0, 1'b1);
        chk("ovr_cnt", 32'(cnt_n), 4);
        chk("ovr_pulses", 32'(ov_cnt_n - ov0), 1);
        for (int d = 1; d <= 4; d++) pop_chk(0, 8'(d), "ovr_pop");
        chk("ovr_cnt_empty", 32'(cnt_n), 0);

        // Short low glitch is a false start
        fe0 = fe_cnt_n; pe0 = pe_cnt_n; ov0 = ov_cnt_n;
        rxd_n = 1'b0;
        repeat (12) @(negedge clk);
        rxd_n = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clk);
        chk("glitch_cnt", 32'(cnt_n), 0);
        chk("glitch_errs", 32'(fe_cnt_n - fe0 + pe_cnt_n - pe0 + ov_cnt_n - ov0), 0);

        // Reset mid-frame with a word already queued
        send(0, 8'h11, 1'b0, 1'b1);
        chk("rstmf_pre_cnt", 32'(cnt_n), 1);
        frame77 = {1'b1, 8'h77, 1'b0};
        $display("tx 8N1 data=77 with reset mid-frame");
        for (int i = 0; i < 10; i++) begin
            if (i == 3) rst = 1'b1;
            rxd_n = frame77[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rxd_n = 1'b1;
        chk("rstmf_cnt_in_rst", 32'(cnt_n), 0);
        rst = 1'b0;
        fe0 = fe_cnt_n; pe0 = pe_cnt_n; ov0 = ov_cnt_n;
        repeat (3 * BIT_CLKS) @(negedge clk);
        chk("rstmf_cnt", 32'(cnt_n), 0);
        chk("rstmf_vld", 32'(vld_n), 0);
        chk("rstmf_errs", 32'(fe_cnt_n - fe0 + pe_cnt_n - pe0 + ov_cnt_n - ov0), 0);

        // Line held low for 12 bit times
        fe0 = fe_cnt_n;
        rxd_n = 1'b0;
        repeat (11 * BIT_CLKS) @(negedge clk);
`ifdef UART_RX_BREAK_DET_EN
        chk("brk_set", 32'(brk_n), 1);
        repeat (BIT_CLKS) @(negedge clk);
        chk("brk_no_fe", 32'(fe_cnt_n - fe0), 0);
        rxd_n = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        chk("brk_clear", 32'(brk_n), 0);
        chk("brk_no_push", 32'(cnt_n), 0);
`else
        chk("hold_brk_tied", 32'(brk_n), 0);
        repeat (BIT_CLKS) @(negedge clk);
        chk("hold_fe", 32'((fe_cnt_n - fe0) >= 1), 1);
        rxd_n = 1'b1;
        repeat (12 * BIT_CLKS) @(negedge clk);
        drain_n();
`endif
        send(0, 8'h5A, 1'b0, 1'b1);
        pop_chk(0, 8'h5A, "post_hold_dout");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
